uart_echo_ctrl: RTL

UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

---
 rtl/uart_echo_ctrl_pkg.sv | 19 +
 rtl/uart_echo_ctrl_buf.sv | 58 +++++
 rtl/uart_echo_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_echo_ctrl_pkg.sv
// uart_echo_ctrl_pkg: shared encodings for the UART echo controller.
// The package holds the transform-select codes, the FSM state type and the
// default data width.
package uart_echo_ctrl_pkg;

  localparam int DBIT_DEFAULT = 8;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_REV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/uart_echo_ctrl_buf.sv
// echo_buf: small word buffer between RX pops and TX pushes.
// RAM writes are synchronous and the head word is read combinationally.
// The pointers carry one extra wrap bit, which lets full and empty be told
// apart without a separate occupancy counter.
module echo_buf
  import uart_echo_ctrl_pkg::*;
#(
  parameter int DW = DBIT_DEFAULT,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // Store the incoming word at the write slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end
  end

  // Advance the pointers; reset empties the buffer and drops stale words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: pops words from a UART RX FIFO, transforms them, buffers
// them and pushes them into a UART TX FIFO.
// Optional feature macro ECHO_STATS_EN: when defined, saturating rx/tx word
// counters are built; otherwise rx_cnt and tx_cnt are tied to zero.
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int DBIT   = DBIT_DEFAULT,
  parameter int BUF_AW = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  last_rx,
  output logic             busy,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] tx_cnt
);

  state_t          r_state;
  state_t          w_nextState;
  logic            w_rxPop;
  logic            w_txPush;
  logic            w_bufFull;
  logic            w_bufEmpty;
  logic [DBIT-1:0] w_head;
  logic [DBIT-1:0] w_xform;
  logic [DBIT-1:0] r_lastRx;

  echo_buf #(
    .DW (DBIT),
    .AW (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rxPop),
    .i_data  (w_xform),
    .i_pop   (w_txPush),
    .o_head  (w_head),
    .o_full  (w_bufFull),
    .o_empty (w_bufEmpty)
  );

  // State register for the accept/drain controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and RX pop strobe; popping only happens while running.
  always_comb begin
    w_nextState = r_state;
    w_rxPop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_rxPop = ~rx_empty & ~w_bufFull;
        if (!en) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (en) begin
          w_nextState = RUN;
        end else if (w_bufEmpty) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Transform the RX head word on its way into the buffer.
  always_comb begin
    w_xform = r_data;
    case (mode)
      MODE_PASS: w_xform = r_data;
      MODE_INC:  w_xform = r_data + {{(DBIT-1){1'b0}}, 1'b1};
      MODE_INV:  w_xform = ~r_data;
      MODE_REV: begin
        for (int i = 0; i < DBIT; i++) begin
          w_xform[i] = r_data[DBIT-1-i];
        end
      end
      default:   w_xform = r_data;
    endcase
  end

  // Remember the raw word of the most recent pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastRx <= '0;
    end else if (w_rxPop) begin
      r_lastRx <= r_data;
    end
  end

  assign w_txPush = ~w_bufEmpty & ~tx_full;
  assign rd_uart  = w_rxPop;
  assign wr_uart  = w_txPush;
  assign w_data   = w_bufEmpty ? '0 : w_head;
  assign last_rx  = r_lastRx;
  assign busy     = (r_state != IDLE) | ~w_bufEmpty;

`ifdef ECHO_STATS_EN
  logic [CNT_W-1:0] r_rxCnt;
  logic [CNT_W-1:0] r_txCnt;

  // Saturating counts of words popped from RX and pushed to TX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxCnt <= '0;
      r_txCnt <= '0;
    end else begin
      if (w_rxPop && (r_rxCnt != '1)) begin
        r_rxCnt <= r_rxCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_txPush && (r_txCnt != '1)) begin
        r_txCnt <= r_txCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rx_cnt = r_rxCnt;
  assign tx_cnt = r_txCnt;
`else
  assign rx_cnt = '0;
  assign tx_cnt = '0;
`endif

endmodule
